// File: rtl/alu_share_arbiter.sv
// Two-port arbiter in front of one shared combinational ALU.
// Each port gets a registered response slot filled one cycle after grant.
package CorePack;
  typedef logic [63:0] data_t;
  typedef enum logic [3:0] {
    ALU_DEFAULT = 4'd0,
    ALU_ADD     = 4'd1,
    ALU_SUB     = 4'd2,
    ALU_AND     = 4'd3,
    ALU_OR      = 4'd4,
    ALU_XOR     = 4'd5,
    ALU_SLL     = 4'd6,
    ALU_SRL     = 4'd7,
    ALU_SRA     = 4'd8,
    ALU_SLT     = 4'd9,
    ALU_SLTU    = 4'd10
  } alu_op_enum;
endpackage

module alu_share_arbiter
  import CorePack::*;
#(
  parameter int RR_EN  = 1,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  alu_op_enum        req0_op,
  output logic              resp0_valid,
  input  logic              resp0_ready,
  output logic [DATA_W-1:0] resp0_res,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  alu_op_enum        req1_op,
  output logic              resp1_valid,
  input  logic              resp1_ready,
  output logic [DATA_W-1:0] resp1_res,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output alu_op_enum        alu_op,
  input  logic [DATA_W-1:0] alu_res
);

  logic elig0;
  logic elig1;
  logic gnt0;
  logic gnt1;
  logic rr_ptr;

  // A full slot may still accept if it drains this same cycle.
  assign elig0 = req0_valid && (!resp0_valid || resp0_ready);
  assign elig1 = req1_valid && (!resp1_valid || resp1_ready);

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (elig0 && elig1) begin
      if ((RR_EN != 0) && rr_ptr) gnt1 = 1'b1;
      else                        gnt0 = 1'b1;
    end else begin
      gnt0 = elig0;
      gnt1 = elig1;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_DEFAULT;
    unique case (1'b1)
      gnt0: begin
        alu_a  = req0_a;
        alu_b  = req0_b;
        alu_op = req0_op;
      end
      gnt1: begin
        alu_a  = req1_a;
        alu_b  = req1_b;
        alu_op = req1_op;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr <= 1'b0;
    end else if (gnt0) begin
      rr_ptr <= 1'b1;
    end else if (gnt1) begin
      rr_ptr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp0_valid <= 1'b0;
      resp0_res   <= '0;
    end else if (gnt0) begin
      resp0_valid <= 1'b1;
      resp0_res   <= alu_res;
    end else if (resp0_ready) begin
      resp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      resp1_valid <= 1'b0;
      resp1_res   <= '0;
    end else if (gnt1) begin
      resp1_valid <= 1'b1;
      resp1_res   <= alu_res;
    end else if (resp1_ready) begin
      resp1_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a round-robin and a fixed-priority instance
// share stimulus and are both checked against a slot/favour reference model.
module tb_alu_share_arbiter;
  import CorePack::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        v0, v1, r0, r1;
  logic [63:0] a0, b0, a1, b1;
  alu_op_enum  op0, op1;

  logic        rq_rdy0 [2];
  logic        rq_rdy1 [2];
  logic        rs_vld0 [2];
  logic        rs_vld1 [2];
  logic [63:0] rs_res0 [2];
  logic [63:0] rs_res1 [2];
  logic [63:0] al_a    [2];
  logic [63:0] al_b    [2];
  logic [63:0] al_res  [2];
  alu_op_enum  al_op   [2];

  int n_tests = 0;
  int n_fail  = 0;

  logic        mfull [2][2];
  logic [63:0] mres  [2][2];
  int          mfav  [2];
  logic        obs_r0 [2];
  logic        obs_r1 [2];

  function automatic logic [63:0] alu_fn(alu_op_enum op, logic [63:0] a, logic [63:0] b);
    case (op)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_AND:  return a & b;
      ALU_OR:   return a | b;
      ALU_XOR:  return a ^ b;
      ALU_SLL:  return a << b[5:0];
      ALU_SRL:  return a >> b[5:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[5:0]);
      ALU_SLT:  return {63'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {63'd0, a < b};
      default:  return 64'd0;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    assign al_res[g] = alu_fn(al_op[g], al_a[g], al_b[g]);
    alu_share_arbiter #(.RR_EN(g == 0 ? 1 : 0), .DATA_W(64)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(v0), .req0_ready(rq_rdy0[g]),
      .req0_a(a0), .req0_b(b0), .req0_op(op0),
      .resp0_valid(rs_vld0[g]), .resp0_ready(r0), .resp0_res(rs_res0[g]),
      .req1_valid(v1), .req1_ready(rq_rdy1[g]),
      .req1_a(a1), .req1_b(b1), .req1_op(op1),
      .resp1_valid(rs_vld1[g]), .resp1_ready(r1), .resp1_res(rs_res1[g]),
      .alu_a(al_a[g]), .alu_b(al_b[g]), .alu_op(al_op[g]),
      .alu_res(al_res[g])
    );
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Winner among eligible ports; instance 0 alternates, instance 1 favours port 0.
  function automatic int pick(int m, bit e0, bit e1);
    if (e0 && e1) return (m == 0) ? mfav[0] : 0;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 2; i++) begin
        mfull[m][i] = 1'b0;
        mres[m][i]  = 64'd0;
      end
      mfav[m] = 0;
    end
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("rst_vld0", 64'(rs_vld0[m]), 64'd0);
      chk("rst_vld1", 64'(rs_vld1[m]), 64'd0);
      chk("rst_res0", rs_res0[m], 64'd0);
      chk("rst_res1", rs_res1[m], 64'd0);
    end
    model_reset();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Called at negedge with inputs applied; checks, then advances one cycle.
  task automatic step();
    int gs [2];
    #1;
    for (int m = 0; m < 2; m++) begin
      bit e0, e1;
      int g;
      e0 = v0 && (!mfull[m][0] || r0);
      e1 = v1 && (!mfull[m][1] || r1);
      g = pick(m, e0, e1);
      gs[m] = g;
      obs_r0[m] = rq_rdy0[m];
      obs_r1[m] = rq_rdy1[m];
      chk("req0_ready", 64'(rq_rdy0[m]), 64'(g == 0));
      chk("req1_ready", 64'(rq_rdy1[m]), 64'(g == 1));
      chk("alu_a", al_a[m], g == 0 ? a0 : g == 1 ? a1 : 64'd0);
      chk("alu_b", al_b[m], g == 0 ? b0 : g == 1 ? b1 : 64'd0);
      chk("alu_op", 64'(al_op[m]),
          64'(g == 0 ? op0 : g == 1 ? op1 : ALU_DEFAULT));
      chk("resp0_valid", 64'(rs_vld0[m]), 64'(mfull[m][0]));
      chk("resp1_valid", 64'(rs_vld1[m]), 64'(mfull[m][1]));
      chk("resp0_res", rs_res0[m], mres[m][0]);
      chk("resp1_res", rs_res1[m], mres[m][1]);
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      if (gs[m] == 0) begin
        mfull[m][0] = 1'b1;
        mres[m][0]  = alu_fn(op0, a0, b0);
      end else if (r0) begin
        mfull[m][0] = 1'b0;
      end
      if (gs[m] == 1) begin
        mfull[m][1] = 1'b1;
        mres[m][1]  = alu_fn(op1, a1, b1);
      end else if (r1) begin
        mfull[m][1] = 1'b0;
      end
      if (gs[m] >= 0) mfav[m] = 1 - gs[m];
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  initial begin
    v0 = 0; v1 = 0; r0 = 0; r1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    op0 = ALU_DEFAULT; op1 = ALU_DEFAULT;
    model_reset();
    @(negedge clk);
    do_reset();

    step();
    // Single-port ADD, then hold the result to reset it mid-operation.
    v0 = 1; a0 = 64'd5; b0 = 64'd7; op0 = ALU_ADD; r0 = 1;
    step();
    chk("add_ready", 64'(obs_r0[0]), 64'd1);
    v0 = 0; r0 = 0;
    chk("add_vld", 64'(rs_vld0[0]), 64'd1);
    chk("add_res", rs_res0[0], 64'd12);
    step();
    do_reset();

    // Contention: round-robin alternates, fixed priority always picks port 0.
    v0 = 1; a0 = 64'd10; b0 = 64'd3; op0 = ALU_SUB;
    v1 = 1; a1 = 64'hF0; b1 = 64'h0F; op1 = ALU_XOR;
    r0 = 1; r1 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_alt0", 64'(obs_r0[0]), 64'(k % 2 == 0));
      chk("rr_alt1", 64'(obs_r1[0]), 64'(k % 2 == 1));
      chk("fp_gnt0", 64'(obs_r0[1]), 64'd1);
      chk("fp_gnt1", 64'(obs_r1[1]), 64'd0);
      if (k % 2 == 0) chk("rr_sub", rs_res0[0], 64'd7);
      else            chk("rr_xor", rs_res1[0], 64'hFF);
    end

    // Backpressure on port 1 while port 0 keeps flowing.
    v0 = 0; v1 = 1; a1 = 64'h1234; b1 = 64'd0; op1 = ALU_ADD;
    step();
    chk("bp_load", rs_res1[0], 64'h1234);
    r1 = 0; a1 = 64'h5000; b1 = 64'd1;
    v0 = 1; r0 = 1; op0 = ALU_OR; a0 = 64'h3; b0 = 64'h30;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_rdy1", 64'(obs_r1[0]), 64'd0);
      chk("bp_rdy0", 64'(obs_r0[0]), 64'd1);
      chk("bp_hold", rs_res1[0], 64'h1234);
      chk("bp_vld", 64'(rs_vld1[0]), 64'd1);
    end
    r1 = 1;
    step();
    chk("bp_regrant", 64'(obs_r1[0]), 64'd1);
    chk("bp_nobubble", 64'(rs_vld1[0]), 64'd1);
    chk("bp_newres", rs_res1[0], 64'h5001);

    // Back-to-back shifts on port 0.
    v1 = 0; v0 = 1; op0 = ALU_SLL; a0 = 64'd1; r0 = 1;
    b0 = 64'd4;
    step();
    chk("b2b_v1", 64'(rs_vld0[0]), 64'd1);
    chk("b2b_r1", rs_res0[0], 64'h10);
    b0 = 64'd8;
    step();
    chk("b2b_v2", 64'(rs_vld0[0]), 64'd1);
    chk("b2b_r2", rs_res0[0], 64'h100);
    b0 = 64'd63;
    step();
    chk("b2b_v3", 64'(rs_vld0[0]), 64'd1);
    chk("b2b_r3", rs_res0[0], 64'h8000000000000000);
    v0 = 0;
    step();

    // Random traffic with occasional resets.
    for (int k = 0; k < 600; k++) begin
      v0  = 1'($urandom_range(0, 3) != 0);
      v1  = 1'($urandom_range(0, 3) != 0);
      r0  = 1'($urandom_range(0, 2) != 0);
      r1  = 1'($urandom_range(0, 2) != 0);
      op0 = alu_op_enum'($urandom_range(1, 10));
      op1 = alu_op_enum'($urandom_range(1, 10));
      a0  = rnd64();
      a1  = rnd64();
      b0  = $urandom_range(0, 1) != 0 ? rnd64() : 64'($urandom_range(0, 63));
      b1  = $urandom_range(0, 1) != 0 ? rnd64() : 64'($urandom_range(0, 63));
      if ($urandom_range(0, 79) == 0) do_reset();
      else step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU instance between two requesters, e.g. the integer execute path (port 0) and the branch/address-calc path (port 1).
- Each requester uses a valid/ready request channel and a valid/ready response channel.
- The block grants at most one operation per cycle, drives the shared ALU operands and op, and captures the ALU result into a per-requester response register.
- Arbitration is round-robin, with an optional fixed-priority mode.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 always wins.
- DATA_W, 64, operand/result width; must match CorePack::data_t.

Ports:
- clk  in  1  core clock, rising edge
- rstn  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_a  in  DATA_W  port 0 operand a
- req0_b  in  DATA_W  port 0 operand b
- req0_op  in  CorePack::alu_op_enum  port 0 operation
- resp0_valid  out  1  port 0 result valid
- resp0_ready  in  1  port 0 consumer ready
- resp0_res  out  DATA_W  port 0 result
- req1_valid, req1_ready, req1_a, req1_b, req1_op, resp1_valid, resp1_ready, resp1_res: same as port 0, for port 1
- alu_a  out  DATA_W  operand a to shared ALU
- alu_b  out  DATA_W  operand b to shared ALU
- alu_op  out  CorePack::alu_op_enum  op to shared ALU
- alu_res  in  DATA_W  combinational result from shared ALU

Behaviour:
- Reset (rstn low, asynchronous):
  - resp0_valid = resp1_valid = 0; resp0_res = resp1_res = 0; rr_ptr = 0 (port 0 favoured).
  - Reset mid-transaction discards any held results.
- Eligibility: elig_i = req_i_valid && (!resp_i_valid || resp_i_ready). A port is never granted while its response slot is full and not draining.
- Arbitration, combinational:
  - Only one eligible port: grant it.
  - Both eligible, RR_EN = 1: grant port rr_ptr.
  - Both eligible, RR_EN = 0: grant port 0.
- req_i_ready = grant_i; the handshake completes when req_i_valid && req_i_ready.
- ALU drive:
  - With a grant: alu_a/alu_b/alu_op = the granted port's operands and op.
  - No grant: alu_a = alu_b = 0, alu_op = ALU_DEFAULT.
- Capture: on the clock edge of a grant to port i, resp_i_res <= alu_res and resp_i_valid <= 1.
- Latency: request accepted in cycle N gives resp_i_valid = 1 in cycle N+1. Throughput is one op per cycle in total across both ports.
- Drain: resp_i_valid && resp_i_ready with no new grant to i in that cycle clears resp_i_valid to 0. resp_i_res holds its last value.
- Simultaneous drain and grant on the same port: resp_i_valid stays 1 and resp_i_res takes the new result. This gives back-to-back results with no bubble.
- Backpressure: while resp_i_valid = 1 and resp_i_ready = 0, resp_i_res and resp_i_valid stay stable; req_i_ready = 0.
- Round-robin pointer, RR_EN = 1:
  - After a grant to port g, rr_ptr <= ~g.
  - With no grant, rr_ptr holds.
  - A port that loses arbitration wins the next cycle it is eligible while the other is also eligible; no starvation.
- Independence: stalling one port's response never blocks the other port.
- Arithmetic: the block passes ALU results through unchanged. There are no width or sign conversions inside the arbiter.
- Requester protocol: requesters must hold req_i_a/b/op stable while req_i_valid = 1 and not ready. The block does not check this.

Test Plan:
- Reset mid-operation: assert rstn = 0 while resp0_valid = 1 -> resp0_valid = 0 and resp0_res = 0 immediately (asynchronous); rr_ptr = 0 after release.
- Single port, ADD: port 0 a = 5, b = 7, op = ALU_ADD in cycle N, resp0_ready = 1 -> req0_ready = 1 in N; resp0_valid = 1 with resp0_res = 12 in N+1; alu_op = ALU_DEFAULT in idle cycles.
- Contention, RR_EN = 1: both ports valid continuously; port 0 SUB 10 - 3, port 1 XOR 0xF0 ^ 0x0F; both resp_ready = 1 -> grants alternate 0,1,0,1; results 7 and 0xFF each appear one cycle after their grant.
- Fixed priority, RR_EN = 0: both valid for 3 cycles -> port 0 granted every cycle; req1_ready = 0 throughout.
- Backpressure: port 1 result 0x1234 held with resp1_ready = 0 for 4 cycles while req1_valid = 1 -> req1_ready = 0 and resp1_res = 0x1234 stable; port 0 still granted each cycle; on resp1_ready = 1, port 1 is granted the same cycle and the new result appears the next cycle with no bubble.
- Back-to-back single port: port 0 issues SLL 1<<4, then 1<<8, then 1<<63 with resp0_ready = 1 -> resp0_valid stays 1 for 3 consecutive cycles with values 0x10, 0x100, 0x8000000000000000.
